// File: rtl/rca8.sv
// rca8: 8-bit ripple-carry adder (eight explicit full-adder stages) with registered
// sum, carry-out and valid. Optional signed-overflow output enabled by RCA8_OVF_EN.
module rca8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       c_in,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  output logic [7:0] Z,
  output logic       c_out,
  output logic       out_valid
`ifdef RCA8_OVF_EN
  ,
  output logic       ovf
`endif
);

  // c[i] is the carry into stage i; c[8] is the carry out of the MSB.
  logic [8:0] c;
  logic [7:0] s;

  assign c[0] = c_in;

  for (genvar i = 0; i < 8; i++) begin : g_stage
    logic p;
    assign p        = X[i] ^ Y[i];
    assign s[i]     = p ^ c[i];
    assign c[i+1]   = (X[i] & Y[i]) | (c[i] & p);
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      Z         <= 8'h00;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z     <= s;
        c_out <= c[8];
      end
    end
  end

`ifdef RCA8_OVF_EN
  // Overflow when the carries into and out of the sign bit disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[8] ^ c[7];
    end
  end
`endif

endmodule

// File: tb/tb_rca8.sv
// Self-checking bench for rca8: directed corner cases plus randomized traffic
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_rca8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       c_in;
  logic [7:0] X;
  logic [7:0] Y;
  logic [7:0] Z;
  logic       c_out;
  logic       out_valid;
`ifdef RCA8_OVF_EN
  logic       ovf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference-model state: what the registered outputs should currently show.
  logic [7:0] exp_z;
  logic       exp_c;
  logic       exp_ovf;

  rca8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .c_in      (c_in),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .c_out     (c_out),
    .out_valid (out_valid)
`ifdef RCA8_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic ci, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    c_in     = ci;
    X        = a;
    Y        = b;
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain-arithmetic model of one accepted add.
  task automatic model_add(input logic ci, input logic [7:0] a, input logic [7:0] b);
    int unsigned u;
    int          sa, sb, ss;
    u  = int'(a) + int'(b) + int'(ci);
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    ss = sa + sb + int'(ci);
    exp_z   = u[7:0];
    exp_c   = (u >= 256);
    exp_ovf = (ss > 127) || (ss < -128);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    tick();
    tests_run++;
    if (Z !== 8'h00 || c_out !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: Z=%h c_out=%b out_valid=%b, want Z=00 c_out=0 out_valid=0",
               Z, c_out, out_valid);
    end
`ifdef RCA8_OVF_EN
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
    end
`endif
    rst = 1'b0;
    exp_z = 8'h00; exp_c = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 8'd10, 8'd20);
    tick();
    tests_run++;
    if (Z !== 8'd31 || c_out !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_add: Z=%0d c_out=%b out_valid=%b, want Z=31 c_out=0 out_valid=1",
               Z, c_out, out_valid);
    end
  endtask

  task automatic test_carry_wrap();
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    tick();
    tests_run++;
    if (Z !== 8'h00 || c_out !== 1'b1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_ff_00: Z=%h c_out=%b out_valid=%b, want Z=00 c_out=1 out_valid=1",
               Z, c_out, out_valid);
    end
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    tests_run++;
    if (Z !== 8'hFF || c_out !== 1'b1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_ff_ff: Z=%h c_out=%b out_valid=%b, want Z=ff c_out=1 out_valid=1",
               Z, c_out, out_valid);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 8'd5, 8'd6);
    tick();
    tests_run++;
    if (Z !== 8'd11 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_load: Z=%0d out_valid=%b, want Z=11 out_valid=1", Z, out_valid);
    end
    drive(1'b0, 1'b1, 8'd1, 8'd1);
    tick();
    tests_run++;
    if (Z !== 8'd11 || c_out !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_idle: Z=%0d c_out=%b out_valid=%b, want Z=11 c_out=0 out_valid=0",
               Z, c_out, out_valid);
    end
    // Carry-out must also hold through an idle cycle.
    drive(1'b1, 1'b0, 8'hF0, 8'h20);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tests_run++;
    if (Z !== 8'h10 || c_out !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_carry: Z=%h c_out=%b out_valid=%b, want Z=10 c_out=1 out_valid=0",
               Z, c_out, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'h33, 8'h44);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hAA, 8'hAA);
    tick();
    rst = 1'b0;
    tests_run++;
    if (Z !== 8'h00 || c_out !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: Z=%h c_out=%b out_valid=%b, want Z=00 c_out=0 out_valid=0",
               Z, c_out, out_valid);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tests_run++;
    if (Z !== 8'h00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_discard: Z=%h out_valid=%b, want Z=00 out_valid=0", Z, out_valid);
    end
    exp_z = 8'h00; exp_c = 1'b0; exp_ovf = 1'b0;
  endtask

`ifdef RCA8_OVF_EN
  task automatic test_overflow();
    drive(1'b1, 1'b0, 8'h7F, 8'h01);
    tick();
    tests_run++;
    if (Z !== 8'h80 || ovf !== 1'b1 || c_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_pos: Z=%h ovf=%b c_out=%b, want Z=80 ovf=1 c_out=0", Z, ovf, c_out);
    end
    drive(1'b1, 1'b0, 8'h80, 8'h80);
    tick();
    tests_run++;
    if (Z !== 8'h00 || ovf !== 1'b1 || c_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_neg: Z=%h ovf=%b c_out=%b, want Z=00 ovf=1 c_out=1", Z, ovf, c_out);
    end
    drive(1'b0, 1'b0, 8'h01, 8'h01);
    tick();
    tests_run++;
    if (ovf !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_hold: ovf=%b out_valid=%b, want ovf=1 out_valid=0", ovf, out_valid);
    end
  endtask
`endif

  // Compare all registered outputs against the model state.
  task automatic compare_model(input string tag, input int idx, input logic want_valid);
    tests_run++;
    if (Z !== exp_z || c_out !== exp_c || out_valid !== want_valid) begin
      tests_failed++;
      $display("FAIL %s[%0d]: Z=%h c_out=%b out_valid=%b, want Z=%h c_out=%b out_valid=%b",
               tag, idx, Z, c_out, out_valid, exp_z, exp_c, want_valid);
    end
`ifdef RCA8_OVF_EN
    if (ovf !== exp_ovf) begin
      tests_failed++;
      $display("FAIL %s_ovf[%0d]: ovf=%b, want %b", tag, idx, ovf, exp_ovf);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic       ci;
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      drive(1'b1, ci, a, b);
      tick();
      model_add(ci, a, b);
      compare_model("b2b", i, 1'b1);
    end
  endtask

  task automatic test_random_gaps();
    logic [7:0] a, b;
    logic       ci, v;
    for (int i = 0; i < 300; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      drive(v, ci, a, b);
      tick();
      if (v) model_add(ci, a, b);
      compare_model("gaps", i, v);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_carry_wrap();
    test_hold();
    test_reset_mid();
`ifdef RCA8_OVF_EN
    test_overflow();
`endif
    test_back_to_back();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
